// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter
// Description : EX-stage ALU. Add/sub, logic ops, signed and unsigned compare,
//               and shifts finish in one cycle. Signed/unsigned multiply and
//               divide run iteratively, one radix-2 step per cycle. Results
//               are registered and flagged with a one-cycle out_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Operation codes
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_AND   = 4'd2;
    localparam logic [3:0] c_OP_NOR   = 4'd3;
    localparam logic [3:0] c_OP_OR    = 4'd4;
    localparam logic [3:0] c_OP_XOR   = 4'd5;
    localparam logic [3:0] c_OP_SLT   = 4'd6;
    localparam logic [3:0] c_OP_SLTU  = 4'd7;
    localparam logic [3:0] c_OP_SLL   = 4'd8;
    localparam logic [3:0] c_OP_SRL   = 4'd9;
    localparam logic [3:0] c_OP_SRA   = 4'd10;
    localparam logic [3:0] c_OP_MULT  = 4'd11;
    localparam logic [3:0] c_OP_MULTU = 4'd12;
    localparam logic [3:0] c_OP_DIV   = 4'd13;
    localparam logic [3:0] c_OP_DIVU  = 4'd14;

    // ------------------------------------------------------------------------
    // Controller states
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [SHW-1:0] c_LAST_STEP = SHW'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [SHW-1:0]   r_count;
    logic             r_busy;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_overflow;

    // Iterative datapath: r_hi/r_lo form the product or remainder/quotient
    // pair, r_opnd holds the multiplicand or divisor magnitude.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_a_orig;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic             w_accept;
    logic             w_is_iter;
    logic             w_is_signed;
    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_accept    = in_valid && !r_busy;
    assign w_is_iter   = (op == c_OP_MULT) || (op == c_OP_MULTU) ||
                         (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_is_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_is_div    = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_a_neg     = w_is_signed && a[WIDTH-1];
    assign w_b_neg     = w_is_signed && b[WIDTH-1];
    assign w_a_mag     = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag     = w_b_neg ? (~b + 1'b1) : b;

    // ------------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;

    assign w_sum   = a + b;
    assign w_diff  = a - b;
    assign w_shamt = b[SHW-1:0];

    // Evaluate the single-cycle result from the live operands.
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_AND:  w_alu_res = a & b;
            c_OP_NOR:  w_alu_res = ~(a | b);
            c_OP_OR:   w_alu_res = a | b;
            c_OP_XOR:  w_alu_res = a ^ b;
            c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            c_OP_SLL:  w_alu_res = a << w_shamt;
            c_OP_SRL:  w_alu_res = a >> w_shamt;
            c_OP_SRA:  w_alu_res = $unsigned($signed(a) >>> w_shamt);
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // One radix-2 step of multiply (shift-add) or divide (restoring)
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_fits;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    // The partial remainder never exceeds 2*divisor-1, so a clear top bit
    // of the difference means the divisor fits.
    assign w_div_fits  = !w_div_diff[WIDTH];

    // Select the next hi/lo pair for the running operation.
    always_comb begin
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_is_div) begin
            w_step_hi = w_div_fits ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], w_div_fits};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Final sign correction and special cases
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin_res;
    logic [WIDTH-1:0]   w_fin_hi;

    assign w_prod_mag = {r_hi, r_lo};
    assign w_prod     = r_neg_q ? (~w_prod_mag + 1'b1) : w_prod_mag;
    assign w_quot     = r_neg_q ? (~r_lo + 1'b1) : r_lo;
    assign w_rem      = r_neg_r ? (~r_hi + 1'b1) : r_hi;

    // Pick the committed mul/div result; most-negative / -1 falls out of the
    // magnitude path naturally as quotient 2^(WIDTH-1), remainder 0.
    always_comb begin
        w_fin_res = w_prod[WIDTH-1:0];
        w_fin_hi  = w_prod[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_fin_res = '1;
                w_fin_hi  = r_a_orig;
            end else begin
                w_fin_res = w_quot;
                w_fin_hi  = w_rem;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: iterative ops go through RUN for WIDTH steps, then DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept && w_is_iter) w_state_next = c_ST_RUN;
            c_ST_RUN:  if (r_count == '0) w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b1;
            r_overflow  <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opnd      <= '0;
            r_a_orig    <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_iter) begin
                            r_busy     <= 1'b1;
                            r_count    <= c_LAST_STEP;
                            r_hi       <= '0;
                            r_lo       <= w_is_div ? w_a_mag : w_b_mag;
                            r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
                            r_a_orig   <= a;
                            r_is_div   <= w_is_div;
                            r_neg_q    <= w_a_neg ^ w_b_neg;
                            r_neg_r    <= w_a_neg;
                            r_div_zero <= (b == '0);
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_res;
                            r_result_hi <= '0;
                            r_zero      <= (w_alu_res == '0);
                            r_overflow  <= w_alu_ovf;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_hi    <= w_step_hi;
                    r_lo    <= w_step_lo;
                    r_count <= r_count - 1'b1;
                end
                c_ST_DONE: begin
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_result    <= w_fin_res;
                    r_result_hi <= w_fin_hi;
                    r_zero      <= (w_fin_res == '0);
                    r_overflow  <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy      = r_busy;
    assign in_ready  = !r_busy;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_iter
// Description : Self-checking bench for alu_iter (WIDTH=32). Directed cases
//               plus randomized operations compared with an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          zero;
    logic          overflow;
    logic          busy;

    int            n_tests = 0;
    int            n_fail  = 0;

    logic [W-1:0]  got_res;
    logic [W-1:0]  got_hi;
    logic          got_zero;
    logic          got_ovf;
    int            got_lat;
    int            busy_bad;

    alu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on 64-bit values.
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic [W-1:0] h, output logic v);
        longint      sx, sy, s;
        logic [63:0] p;
        int          sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y[4:0]);
        r = '0; h = '0; v = 1'b0;
        case (o)
            4'd0:  begin s = sx + sy; r = s[31:0]; v = (s != longint'($signed(r))); end
            4'd1:  begin s = sx - sy; r = s[31:0]; v = (s != longint'($signed(r))); end
            4'd2:  r = x & y;
            4'd3:  r = ~(x | y);
            4'd4:  r = x | y;
            4'd5:  r = x ^ y;
            4'd6:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd7:  r = (x < y) ? 32'd1 : 32'd0;
            4'd8:  r = x << sh;
            4'd9:  r = x >> sh;
            4'd10: begin s = sx >>> sh; r = s[31:0]; end
            4'd11: begin s = sx * sy; r = s[31:0]; h = s[63:32]; end
            4'd12: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; h = p[63:32]; end
            4'd13: begin
                if (y == 0) begin r = '1; h = x; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin r = x; h = '0; end
                else begin s = sx / sy; r = s[31:0]; s = sx % sy; h = s[31:0]; end
            end
            4'd14: begin
                if (y == 0) begin r = '1; h = x; end
                else begin r = x / y; h = x % y; end
            end
            default: r = '0;
        endcase
    endtask

    // Issue one request, wait for its out_valid, capture outputs and latency
    // (edges from accept to out_valid). With hold set, a second request (ADD)
    // is kept pending while the first one is busy.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit hold);
        int k;
        busy_bad = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        if (hold) begin
            op = 4'd0; a = 32'd1; b = 32'd1;
        end else begin
            in_valid = 1'b0;
        end
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            if (!busy || in_ready) busy_bad++;
            k++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        got_lat  = k;
        got_res  = result;
        got_hi   = result_hi;
        got_zero = zero;
        got_ovf  = overflow;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (result !== 32'd0)   begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        n_tests++; if (result_hi !== 32'd0) begin n_fail++; $display("FAIL reset_result_hi: got %h want 0", result_hi); end
        n_tests++; if (zero !== 1'b1)      begin n_fail++; $display("FAIL reset_zero: got %b want 1", zero); end
        n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        reset = 1'b0;
    endtask

    task automatic test_add_sub();
        run_op(4'd0, 32'h7FFFFFFF, 32'd1, 1'b0);
        n_tests++; if (got_res !== 32'h80000000) begin n_fail++; $display("FAIL add_res: got %h want 80000000", got_res); end
        n_tests++; if (got_ovf !== 1'b1)  begin n_fail++; $display("FAIL add_ovf: got %b want 1", got_ovf); end
        n_tests++; if (got_zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", got_zero); end
        n_tests++; if (got_lat != 0)      begin n_fail++; $display("FAIL add_latency: got %0d want 0", got_lat); end
        run_op(4'd1, 32'd5, 32'd5, 1'b0);
        n_tests++; if (got_res !== 32'd0) begin n_fail++; $display("FAIL sub_res: got %h want 0", got_res); end
        n_tests++; if (got_zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b want 1", got_zero); end
        n_tests++; if (got_ovf !== 1'b0)  begin n_fail++; $display("FAIL sub_ovf: got %b want 0", got_ovf); end
    endtask

    task automatic test_cmp_shift();
        run_op(4'd6, 32'hFFFFFFFF, 32'd1, 1'b0);
        n_tests++; if (got_res !== 32'd1) begin n_fail++; $display("FAIL slt: got %h want 1", got_res); end
        run_op(4'd7, 32'hFFFFFFFF, 32'd1, 1'b0);
        n_tests++; if (got_res !== 32'd0) begin n_fail++; $display("FAIL sltu: got %h want 0", got_res); end
        run_op(4'd10, 32'h80000000, 32'd4, 1'b0);
        n_tests++; if (got_res !== 32'hF8000000) begin n_fail++; $display("FAIL sra: got %h want f8000000", got_res); end
        run_op(4'd9, 32'h80000000, 32'd4, 1'b0);
        n_tests++; if (got_res !== 32'h08000000) begin n_fail++; $display("FAIL srl: got %h want 08000000", got_res); end
        n_tests++; if (got_hi !== 32'd0) begin n_fail++; $display("FAIL srl_hi: got %h want 0", got_hi); end
    endtask

    task automatic test_mul();
        run_op(4'd11, 32'hFFFFFFFD, 32'd7, 1'b1);
        n_tests++; if (got_res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", got_res); end
        n_tests++; if (got_hi !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", got_hi); end
        n_tests++; if (got_lat != 33)  begin n_fail++; $display("FAIL mult_latency: got %0d want 33", got_lat); end
        n_tests++; if (busy_bad != 0)  begin n_fail++; $display("FAIL mult_busy: got %0d bad cycles want 0", busy_bad); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mult_held_req: got out_valid %b want 0", out_valid); end
        run_op(4'd12, 32'hFFFFFFFF, 32'd2, 1'b0);
        n_tests++; if (got_res !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", got_res); end
        n_tests++; if (got_hi !== 32'd1) begin n_fail++; $display("FAIL multu_hi: got %h want 1", got_hi); end
    endtask

    task automatic test_div();
        run_op(4'd13, 32'hFFFFFFF9, 32'd2, 1'b0);
        n_tests++; if (got_res !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_q: got %h want fffffffd", got_res); end
        n_tests++; if (got_hi !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL div_r: got %h want ffffffff", got_hi); end
        run_op(4'd14, 32'd7, 32'd0, 1'b0);
        n_tests++; if (got_res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_q: got %h want ffffffff", got_res); end
        n_tests++; if (got_hi !== 32'd7) begin n_fail++; $display("FAIL divu0_r: got %h want 7", got_hi); end
        run_op(4'd13, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        n_tests++; if (got_res !== 32'h80000000) begin n_fail++; $display("FAIL divmin_q: got %h want 80000000", got_res); end
        n_tests++; if (got_hi !== 32'd0)  begin n_fail++; $display("FAIL divmin_r: got %h want 0", got_hi); end
        n_tests++; if (got_ovf !== 1'b0)  begin n_fail++; $display("FAIL divmin_ovf: got %b want 0", got_ovf); end
    endtask

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        op = 4'd0; a = 32'd100; b = 32'd23; in_valid = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || result !== 32'd123) begin n_fail++; $display("FAIL b2b_add: got v=%b %h want v=1 0000007b", out_valid, result); end
        op = 4'd2; a = 32'hF0F0F0F0; b = 32'h0FF00FF0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || result !== 32'h00F000F0) begin n_fail++; $display("FAIL b2b_and: got v=%b %h want v=1 00f000f0", out_valid, result); end
        op = 4'd4; a = 32'h12000000; b = 32'h00000034;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || result !== 32'h12000034) begin n_fail++; $display("FAIL b2b_or: got v=%b %h want v=1 12000034", out_valid, result); end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", out_valid); end

        // DIV followed immediately by a held ADD request
        op = 4'd13; a = 32'hFFFFFF9C; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        op = 4'd0; a = 32'd20; b = 32'd22;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            k++;
            @(negedge clk);
        end
        n_tests++; if (k != 33) begin n_fail++; $display("FAIL b2b_div_latency: got %0d want 33", k); end
        n_tests++; if (result !== 32'hFFFFFFF2 || result_hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL b2b_div: got %h/%h want fffffff2/fffffffe", result, result_hi); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || result !== 32'd42) begin n_fail++; $display("FAIL b2b_add_after_div: got v=%b %h want v=1 0000002a", out_valid, result); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        run_op(4'd0, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        op = 4'd11; a = 32'h12345; b = 32'h6789; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got busy=%b rdy=%b want 0/1", busy, in_ready); end
        n_tests++; if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: got res=%h z=%b v=%b want 0/1/0", result, zero, out_valid); end
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses want 0", pulses); end
        run_op(4'd0, 32'd3, 32'd4, 1'b0);
        n_tests++; if (got_res !== 32'd7 || got_lat != 0) begin n_fail++; $display("FAIL abort_next_add: got %h lat %0d want 7 lat 0", got_res, got_lat); end
    endtask

    task automatic test_random();
        logic [3:0]   o;
        logic [W-1:0] x, y, er, eh;
        logic         ev;
        int           el;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: x = 32'h80000000;
                1: y = 32'hFFFFFFFF;
                2: y = 32'd0;
                3: x = 32'h7FFFFFFF;
                4: y = 32'($urandom_range(0, 40));
                default: ;
            endcase
            model(o, x, y, er, eh, ev);
            el = (o >= 4'd11 && o <= 4'd14) ? 33 : 0;
            run_op(o, x, y, 1'b0);
            n_tests++;
            if (got_res !== er || got_hi !== eh || got_ovf !== ev || got_zero !== (er == 0) ||
                got_lat != el || busy_bad != 0) begin
                n_fail++;
                $display("FAIL rand op=%0d a=%h b=%h: got %h/%h ovf=%b z=%b lat=%0d bb=%0d want %h/%h ovf=%b z=%b lat=%0d",
                         o, x, y, got_res, got_hi, got_ovf, got_zero, got_lat, busy_bad,
                         er, eh, ev, (er == 0), el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_cmp_shift();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
